alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Upstream feeder for the 4-bit ALU stage. Collects operand A, operand B and a 3-bit command from
//  shared 4-bit switches, one debounced ENTER press per field, then issues them to the ALU with a
//  valid/ready handshake. Holds issued values stable so the ALU's clocked result is deterministic.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive clk cycles btn_enter must stay stable before the debounced level changes (>=2)
//  CNT_W            5   debounce counter width; must hold DEBOUNCE_CYCLES
// PORTS
//  clk          in   1  system clock, all state on posedge
//  rst_n        in   1  asynchronous active-low reset
//  sw_data      in   4  switch value; sampled on accepted ENTER
//  btn_enter    in   1  raw push button, asynchronous to clk, active-high
//  alu_ready    in   1  ALU accepts the issued operation this cycle
//  alu_command  out  3  command to ALU (sw_data[2:0] at OP entry)
//  alu_a        out  4  operand A to ALU
//  alu_b        out  4  operand B to ALU
//  alu_valid    out  1  issued operation valid; held until alu_ready
//  stage        out  2  current field for LEDs: 0=A, 1=B, 2=OP, 3=ISSUE
//  alu_ans      in   4  ALU result; present only with OPSEQ_CHAIN_EN
// BEHAVIOUR
//  Reset (async assert, sync release): state=GET_A; alu_a=alu_b=0, alu_command=0, alu_valid=0,
//  stage=0, synchronizer flops, debounced level and counter=0.
//  Input path: btn_enter -> 2-flop synchronizer -> debouncer. Counter clears whenever synced level
//  equals debounced level; otherwise it increments; on reaching DEBOUNCE_CYCLES-1 debounced level
//  flips and counter clears. enter_pulse = 1-cycle pulse on debounced rising edge only.
//  Press-to-pulse latency: 2 sync cycles + DEBOUNCE_CYCLES cycles. Release generates no pulse.
//  FSM (state registered; stage equals state encoding):
//   GET_A  : enter_pulse -> alu_a<=sw_data, go GET_B
//   GET_B  : enter_pulse -> alu_b<=sw_data, go GET_OP
//   GET_OP : enter_pulse -> alu_command<=sw_data[2:0], alu_valid<=1, go ISSUE (sw_data[3] ignored)
//   ISSUE  : alu_valid=1; alu_a/alu_b/alu_command frozen; on alu_ready: alu_valid<=0, go GET_A
//  alu_valid asserts the cycle after the OP enter_pulse; deasserts the cycle after alu_ready sampled high.
//  alu_ready high in the first ISSUE cycle -> exactly one valid cycle. alu_ready ignored outside ISSUE.
//  enter_pulse in ISSUE is discarded (not queued). Operand registers keep last values after ISSUE until
//  overwritten, so ALU inputs never glitch to 0 between operations.
//  rst_n low mid-sequence (any state, incl. ISSUE with valid high) -> immediate return to reset values;
//  partial entries discarded; a held button after release of reset produces a pulse only once
//  debounced (debounced level starts at 0).
//  No arithmetic performed here; widths pass through unchanged.
// CONFIGURATION
//  OPSEQ_CHAIN_EN defined: alu_ans port exists. On alu_ready in ISSUE: alu_a<=alu_ans and next state is
//   GET_B (GET_A skipped) - accumulator chaining. Reset still starts in GET_A. stage reads 1 after issue.
//  OPSEQ_CHAIN_EN undefined: no alu_ans port; ISSUE always returns to GET_A; alu_a unchanged.
// TESTING  (bench uses DEBOUNCE_CYCLES=4)
//  T1 press/sw: A=4'h3, B=4'h5, OP=3'b000, alu_ready tied 1 -> alu_a=3 alu_b=5 cmd=0, alu_valid high
//     exactly 1 cycle, stage 0->1->2->3->0.
//  T2 bounce: toggle btn_enter every cycle for 3 cycles then hold high 10 cycles -> exactly one
//     enter_pulse, stage advances by 1 only; held release gives no advance.
//  T3 backpressure: reach ISSUE with alu_ready=0 for 5 cycles, change sw_data and press ENTER -> valid
//     held, alu_a/b/cmd unchanged, stage=3; raise alu_ready -> valid drops next cycle, stage=0.
//  T4 reset mid-op: in GET_OP after A=7,B=2 pull rst_n low asynchronously (between edges) -> outputs
//     zero immediately, stage=0; next full entry works normally.
//  T5 OP width: enter OP with sw_data=4'hE -> alu_command=3'b110.
//  T6 (OPSEQ_CHAIN_EN) A=1,B=2,OP=000, alu_ans=4'h3 at handshake -> alu_a=3, stage=1; enter B=4 ->
//     next issue has alu_a=3 alu_b=4.

Source files
------------

// File: rtl/alu_operand_sequencer_if.sv
// Switch/button inputs and the ALU issue bus of the operand sequencer.
// master = sequencer side; slave = panel/ALU side (drives inputs, consumes the issue).
// alu_ans exists only when OPSEQ_CHAIN_EN is defined (accumulator chaining).
interface alu_operand_sequencer_if;
    logic [3:0] sw_data;
    logic       btn_enter;
    logic       alu_ready;
    logic [2:0] alu_command;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_valid;
    logic [1:0] stage;
`ifdef OPSEQ_CHAIN_EN
    logic [3:0] alu_ans;
`endif

    modport master (
        input  sw_data,
        input  btn_enter,
        input  alu_ready,
`ifdef OPSEQ_CHAIN_EN
        input  alu_ans,
`endif
        output alu_command,
        output alu_a,
        output alu_b,
        output alu_valid,
        output stage
    );

    modport slave (
        output sw_data,
        output btn_enter,
        output alu_ready,
`ifdef OPSEQ_CHAIN_EN
        output alu_ans,
`endif
        input  alu_command,
        input  alu_a,
        input  alu_b,
        input  alu_valid,
        input  stage
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and a 3-bit command from shared switches (one debounced ENTER each) and issues them to the ALU.
// Latency: press-to-pulse = 2 sync + DEBOUNCE_CYCLES cycles; alu_valid rises the cycle after the OP pulse.
// Backpressure: alu_valid and operands held frozen until alu_ready; ENTER in ISSUE is dropped. Option macro: OPSEQ_CHAIN_EN.
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_operand_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        GET_A  = 2'd0,
        GET_B  = 2'd1,
        GET_OP = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enter_pulse;

    state_t           state_q;
    logic [3:0]       a_q, b_q;
    logic [2:0]       cmd_q;
    logic             vld_q;

    // Two-flop synchronizer for the asynchronous push button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.btn_enter;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state: level flips only after CNT_MAX+1 consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d = ~deb_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounced level and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    // Single-cycle strobe on the debounced rising edge; releases never strobe.
    assign enter_pulse = deb_d & ~deb_q;

    // Entry/issue FSM; operands keep their last values between operations so the ALU never sees zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GET_A;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            cmd_q   <= 3'd0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (enter_pulse) begin
                        a_q     <= bus.sw_data;
                        state_q <= GET_B;
                    end
                end
                GET_B: begin
                    if (enter_pulse) begin
                        b_q     <= bus.sw_data;
                        state_q <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (enter_pulse) begin
                        cmd_q   <= bus.sw_data[2:0];
                        vld_q   <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.alu_ready) begin
                        vld_q   <= 1'b0;
`ifdef OPSEQ_CHAIN_EN
                        a_q     <= bus.alu_ans;
                        state_q <= GET_B;
`else
                        state_q <= GET_A;
`endif
                    end
                end
                default: state_q <= GET_A;
            endcase
        end
    end

    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_command = cmd_q;
    assign bus.alu_valid   = vld_q;
    assign bus.stage       = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    alu_operand_sequencer_if bus ();

    alu_operand_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] cmd;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   hs_cnt     = 0;
    int   vld_cycles = 0;

`ifdef OPSEQ_CHAIN_EN
    localparam logic [1:0] POST_STAGE = 2'd1;
`else
    localparam logic [1:0] POST_STAGE = 2'd0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted issue is compared against the oldest expected operation.
    always @(negedge clk) begin
        if (rst_n && bus.alu_valid) vld_cycles++;
        if (rst_n && bus.alu_valid && bus.alu_ready) begin
            exp_t e;
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got a=%0h b=%0h cmd=%0h with nothing expected",
                         bus.alu_a, bus.alu_b, bus.alu_command);
            end else begin
                e = exp_q.pop_front();
                check("issue_a", 32'(bus.alu_a), 32'(e.a));
                check("issue_b", 32'(bus.alu_b), 32'(e.b));
                check("issue_cmd", 32'(bus.alu_command), 32'(e.cmd));
            end
        end
    end

    task automatic press(input logic [3:0] val);
        @(negedge clk);
        bus.sw_data   = val;
        bus.btn_enter = 1'b1;
        repeat (10) @(negedge clk);
        bus.btn_enter = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Stage after a completed issue; chained builds restart from reset to keep flows uniform.
    task automatic after_issue(input string name);
        check(name, 32'(bus.stage), 32'(POST_STAGE));
`ifdef OPSEQ_CHAIN_EN
        do_reset();
`endif
    endtask

    initial begin
        int v0;
        rst_n         = 1'b0;
        bus.sw_data   = 4'h0;
        bus.btn_enter = 1'b0;
        bus.alu_ready = 1'b0;
`ifdef OPSEQ_CHAIN_EN
        bus.alu_ans   = 4'h0;
`endif
        repeat (3) @(negedge clk);
        check("rst_a", 32'(bus.alu_a), 0);
        check("rst_b", 32'(bus.alu_b), 0);
        check("rst_cmd", 32'(bus.alu_command), 0);
        check("rst_valid", 32'(bus.alu_valid), 0);
        check("rst_stage", 32'(bus.stage), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: basic entry with ALU always ready
        bus.alu_ready = 1'b1;
        v0 = vld_cycles;
        press(4'h3);
        check("t1_stage_b", 32'(bus.stage), 1);
        check("t1_a", 32'(bus.alu_a), 3);
        press(4'h5);
        check("t1_stage_op", 32'(bus.stage), 2);
        exp_q.push_back('{a: 4'h3, b: 4'h5, cmd: 3'b000});
        press(4'h0);
        check("t1_valid_cycles", 32'(vld_cycles - v0), 1);
        check("t1_valid_low", 32'(bus.alu_valid), 0);
`ifdef OPSEQ_CHAIN_EN
        check("t1_a_hold", 32'(bus.alu_a), 0);
`else
        check("t1_a_hold", 32'(bus.alu_a), 3);
`endif
        check("t1_b_hold", 32'(bus.alu_b), 5);
        after_issue("t1_stage_after");

        // T2: bouncing press produces one advance only
        @(negedge clk);
        bus.sw_data   = 4'h9;
        bus.btn_enter = 1'b1;
        @(negedge clk);
        bus.btn_enter = 1'b0;
        @(negedge clk);
        bus.btn_enter = 1'b1;
        repeat (10) @(negedge clk);
        check("t2_stage_held", 32'(bus.stage), 1);
        bus.btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        check("t2_stage_release", 32'(bus.stage), 1);
        check("t2_a", 32'(bus.alu_a), 9);

        // T3 + T5: backpressure, and sw_data[3] dropped from the command
        bus.alu_ready = 1'b0;
        press(4'hA);
        exp_q.push_back('{a: 4'h9, b: 4'hA, cmd: 3'b110});
        press(4'hE);
        repeat (5) @(negedge clk);
        check("t3_valid_held", 32'(bus.alu_valid), 1);
        check("t3_stage_issue", 32'(bus.stage), 3);
        check("t5_cmd", 32'(bus.alu_command), 32'h6);
        press(4'h1);
        check("t3_stage_ignored", 32'(bus.stage), 3);
        check("t3_a_frozen", 32'(bus.alu_a), 32'h9);
        check("t3_b_frozen", 32'(bus.alu_b), 32'hA);
        check("t3_cmd_frozen", 32'(bus.alu_command), 32'h6);
        check("t3_valid_still", 32'(bus.alu_valid), 1);
        bus.alu_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_valid_drop", 32'(bus.alu_valid), 0);
        after_issue("t3_stage_after");

        // T4: asynchronous reset in GET_OP discards partial entry
        press(4'h7);
        press(4'h2);
        check("t4_stage_op", 32'(bus.stage), 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t4_rst_a", 32'(bus.alu_a), 0);
        check("t4_rst_b", 32'(bus.alu_b), 0);
        check("t4_rst_cmd", 32'(bus.alu_command), 0);
        check("t4_rst_valid", 32'(bus.alu_valid), 0);
        check("t4_rst_stage", 32'(bus.stage), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        press(4'hC);
        press(4'h4);
        exp_q.push_back('{a: 4'hC, b: 4'h4, cmd: 3'b101});
        press(4'h5);
        after_issue("t4_stage_after");

`ifdef OPSEQ_CHAIN_EN
        // T6: accumulator chaining feeds the result back as operand A
        bus.alu_ans = 4'h3;
        press(4'h1);
        press(4'h2);
        exp_q.push_back('{a: 4'h1, b: 4'h2, cmd: 3'b000});
        press(4'h0);
        check("t6_a_chain", 32'(bus.alu_a), 3);
        check("t6_stage_b", 32'(bus.stage), 1);
        press(4'h4);
        check("t6_stage_op", 32'(bus.stage), 2);
        exp_q.push_back('{a: 4'h3, b: 4'h4, cmd: 3'b000});
        press(4'h0);
        check("t6_stage_after", 32'(bus.stage), 1);
        check("hs_total", 32'(hs_cnt), 5);
`else
        check("hs_total", 32'(hs_cnt), 3);
`endif
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
